// File: rtl/instance5_scheduler.sv
// Round-robin scheduler sharing one instance5 datapath among NREQ requesters.
// One bundle in flight: accept, hold operands LATENCY cycles, return result.
module instance5_scheduler #(
    parameter int NREQ    = 4,
    parameter int LATENCY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]    req_b,
    input  logic [8*NREQ-1:0]    req_c,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [3:0]           rsp_d,
    output logic [31:0]          dp_a,
    output logic [0:7]           dp_b,
    output logic [7:0]           dp_c,
    input  logic [3:0]           dp_d,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_ptr;
    logic [PW-1:0]       r_gnt;
    logic [CW-1:0]       r_cnt;
    logic [NREQ-1:0]     r_rsp_valid;
    logic [3:0]          r_rsp_d;
    logic [31:0]         r_dp_a;
    logic [0:7]          r_dp_b;
    logic [7:0]          r_dp_c;
    logic                r_busy;

    logic                w_found;
    logic [PW-1:0]       w_sel;
    logic [PW-1:0]       w_idx;
    logic [PW-1:0]       w_ptr_nxt;
    logic [NREQ-1:0]     w_ready;

    // First valid requester at or after the pointer, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = PW'((int'(r_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // Accept strobe only in IDLE; winner gets lowest priority next time
    always_comb begin
        w_ready   = '0;
        w_ptr_nxt = (w_sel == PW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
        if (r_state == S_IDLE && w_found) begin
            w_ready[w_sel] = 1'b1;
        end
    end

    // Control FSM with registered datapath drive and response outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_cnt       <= '0;
            r_rsp_valid <= '0;
            r_rsp_d     <= '0;
            r_dp_a      <= '0;
            r_dp_b      <= '0;
            r_dp_c      <= '0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_dp_a  <= req_a[32*int'(w_sel) +: 32];
                        r_dp_b  <= req_b[8*int'(w_sel) +: 8];
                        r_dp_c  <= req_c[8*int'(w_sel) +: 8];
                        r_gnt   <= w_sel;
                        r_ptr   <= w_ptr_nxt;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_busy  <= 1'b1;
                        r_state <= S_WAIT;
                    end else begin
                        r_dp_a <= '0;
                        r_dp_b <= '0;
                        r_dp_c <= '0;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_rsp_d     <= dp_d;
                        r_rsp_valid <= NREQ'(1) << r_gnt;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= '0;
                    r_dp_a      <= '0;
                    r_dp_b      <= '0;
                    r_dp_c      <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_d     = r_rsp_d;
    assign dp_a      = r_dp_a;
    assign dp_b      = r_dp_b;
    assign dp_c      = r_dp_c;
    assign busy      = r_busy;

endmodule
